// File: rtl/reaction_timer_if.sv
// Signal bundle between the reaction-time controller and its neighbours.
// With REACTION_TIMER_STATS_EN defined it also carries best_ms/avg_ms.
interface reaction_timer_if #(
  parameter int W = 14
);
  logic         tick_1ms;
  logic         start_pulse;
  logic         delay_pulse;
  logic         resp_pulse;
  logic         stim_led;
  logic [W-1:0] reaction_ms;
  logic         result_valid;
  logic         false_start;
  logic         timeout;
  logic         busy;
`ifdef REACTION_TIMER_STATS_EN
  logic [W-1:0] best_ms;
  logic [W-1:0] avg_ms;

  modport master (
    output tick_1ms, start_pulse, delay_pulse, resp_pulse,
    input  stim_led, reaction_ms, result_valid, false_start, timeout, busy,
    input  best_ms, avg_ms
  );
  modport slave (
    input  tick_1ms, start_pulse, delay_pulse, resp_pulse,
    output stim_led, reaction_ms, result_valid, false_start, timeout, busy,
    output best_ms, avg_ms
  );
`else
  modport master (
    output tick_1ms, start_pulse, delay_pulse, resp_pulse,
    input  stim_led, reaction_ms, result_valid, false_start, timeout, busy
  );
  modport slave (
    input  tick_1ms, start_pulse, delay_pulse, resp_pulse,
    output stim_led, reaction_ms, result_valid, false_start, timeout, busy
  );
`endif
endinterface

// File: rtl/reaction_timer.sv
// Reaction-time controller: arm, light stimulus, count ms to response; flags false start/timeout.
// Latency: result_valid one cycle after resp_pulse; stats (REACTION_TIMER_STATS_EN) one cycle later.
// Backpressure: none, pulse inputs are consumed in the cycle they are sampled.
module reaction_timer #(
  parameter int W      = 14,
  parameter int MAX_MS = 9999,
  parameter int TRIALS = 4
) (
  input logic        clk,
  input logic        rst,
  reaction_timer_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_STIM = 3'd1;
  localparam logic [2:0] MEASURE   = 3'd2;
  localparam logic [2:0] DONE      = 3'd3;
  localparam logic [2:0] FAULT     = 3'd4;

  localparam logic [W-1:0] MAX_V  = W'(MAX_MS);
  localparam logic [W-1:0] LAST_V = W'(MAX_MS - 1);

  if (TRIALS < 1 || (TRIALS & (TRIALS - 1)) != 0) begin : g_bad_trials
    $error("TRIALS must be a power of 2");
  end

  logic [2:0]   state;
  logic [W-1:0] count;
  logic [W-1:0] res_q;
  logic         valid_q;
  logic         fs_q;
  logic         to_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_pulse) begin
            state <= WAIT_STIM;
            count <= '0;
            fs_q  <= 1'b0;
            to_q  <= 1'b0;
          end
        end
        WAIT_STIM: begin
          // A response coinciding with stimulus onset is still a false start.
          if (bus.resp_pulse) begin
            state <= FAULT;
            fs_q  <= 1'b1;
          end else if (bus.delay_pulse) begin
            state <= MEASURE;
            count <= '0;
          end
        end
        MEASURE: begin
          if (bus.start_pulse) begin
            state <= WAIT_STIM;
            count <= '0;
          end else if (bus.resp_pulse) begin
            state   <= DONE;
            res_q   <= count;
            valid_q <= 1'b1;
          end else if (bus.tick_1ms) begin
            if (count == LAST_V) begin
              state <= FAULT;
              to_q  <= 1'b1;
              res_q <= MAX_V;
              count <= MAX_V;
            end else if (count < MAX_V) begin
              count <= count + 1'b1;
            end
          end
        end
        DONE, FAULT: begin
          if (bus.start_pulse) begin
            state <= WAIT_STIM;
            count <= '0;
            fs_q  <= 1'b0;
            to_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stim_led     = (state == MEASURE);
  assign bus.busy         = (state == WAIT_STIM) || (state == MEASURE);
  assign bus.reaction_ms  = res_q;
  assign bus.result_valid = valid_q;
  assign bus.false_start  = fs_q;
  assign bus.timeout      = to_q;

`ifdef REACTION_TIMER_STATS_EN
  localparam int LG = $clog2(TRIALS);

  logic [W-1:0]    hist [TRIALS];
  logic [W+LG-1:0] sum_q;
  logic [W+LG-1:0] sum_nxt;
  logic [W-1:0]    best_q;
  logic [W-1:0]    avg_q;

  // Running sum: drop the oldest slot, add the newest result.
  always_comb begin
    sum_nxt = sum_q - (W+LG)'(hist[TRIALS-1]) + (W+LG)'(res_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TRIALS; i++) hist[i] <= '0;
      sum_q  <= '0;
      best_q <= MAX_V;
      avg_q  <= '0;
    end else if (valid_q) begin
      hist[0] <= res_q;
      for (int i = 1; i < TRIALS; i++) hist[i] <= hist[i-1];
      sum_q <= sum_nxt;
      avg_q <= sum_nxt[W+LG-1:LG];
      if (res_q < best_q) best_q <= res_q;
    end
  end

  assign bus.best_ms = best_q;
  assign bus.avg_ms  = avg_q;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: scoreboard of expected result/false-start/timeout events plus level checks.
module tb_reaction_timer;

  localparam int W = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  reaction_timer_if #(.W(W)) bus ();

  reaction_timer #(.W(W), .MAX_MS(9999), .TRIALS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int kind;  // 0 result, 1 false start, 2 timeout
    int val;   // reaction_ms at the event
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d value %0d, expected none", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_value", val, e.val);
    end
  endtask

  // Monitor: result_valid pulses and rising edges of the fault flags.
  initial begin
    logic prev_fs, prev_to;
    prev_fs = 1'b0;
    prev_to = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.result_valid) got_ev(0, int'(bus.reaction_ms));
      if (bus.false_start && !prev_fs) got_ev(1, int'(bus.reaction_ms));
      if (bus.timeout && !prev_to) got_ev(2, int'(bus.reaction_ms));
      prev_fs = bus.false_start;
      prev_to = bus.timeout;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic s, input logic d, input logic r, input logic t);
    bus.start_pulse = s;
    bus.delay_pulse = d;
    bus.resp_pulse  = r;
    bus.tick_1ms    = t;
    step(1);
    bus.start_pulse = 1'b0;
    bus.delay_pulse = 1'b0;
    bus.resp_pulse  = 1'b0;
    bus.tick_1ms    = 1'b0;
  endtask

  task automatic ticks(input int n);
    bus.tick_1ms = 1'b1;
    step(n);
    bus.tick_1ms = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stim_led"}, int'(bus.stim_led), 0);
    check({tag, "_reaction_ms"}, int'(bus.reaction_ms), 0);
    check({tag, "_result_valid"}, int'(bus.result_valid), 0);
    check({tag, "_false_start"}, int'(bus.false_start), 0);
    check({tag, "_timeout"}, int'(bus.timeout), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  task automatic good_trial(input int ms);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    ticks(ms);
    expect_ev(0, ms);
    pulse(0, 0, 1, 0);
    step(2);
  endtask

  initial begin
    bus.start_pulse = 1'b0;
    bus.delay_pulse = 1'b0;
    bus.resp_pulse  = 1'b0;
    bus.tick_1ms    = 1'b0;
    step(2);
    check_idle_outputs("reset");
`ifdef REACTION_TIMER_STATS_EN
    check("reset_best_ms", int'(bus.best_ms), 9999);
    check("reset_avg_ms", int'(bus.avg_ms), 0);
`endif
    rst = 1'b1;
    step(1);

    // Good trial of 237 ms
    pulse(1, 0, 0, 0);
    check("armed_busy", int'(bus.busy), 1);
    check("armed_stim_led", int'(bus.stim_led), 0);
    pulse(0, 1, 0, 0);
    check("measure_stim_led", int'(bus.stim_led), 1);
    ticks(237);
    check("measure_busy", int'(bus.busy), 1);
    expect_ev(0, 237);
    pulse(0, 0, 1, 0);
    check("done_reaction_ms", int'(bus.reaction_ms), 237);
    check("done_result_valid", int'(bus.result_valid), 1);
    step(1);
    check("done_valid_cleared", int'(bus.result_valid), 0);
    check("done_stim_led", int'(bus.stim_led), 0);
    check("done_false_start", int'(bus.false_start), 0);
    check("done_timeout", int'(bus.timeout), 0);

    // False start, later delay_pulse ignored
    pulse(1, 0, 0, 0);
    expect_ev(1, 237);
    pulse(0, 0, 1, 0);
    check("fs_flag", int'(bus.false_start), 1);
    check("fs_stim_led", int'(bus.stim_led), 0);
    check("fs_busy", int'(bus.busy), 0);
    pulse(0, 1, 0, 0);
    check("fs_delay_ignored_stim", int'(bus.stim_led), 0);
    check("fs_reaction_kept", int'(bus.reaction_ms), 237);

    // Timeout after 9999 ticks
    pulse(1, 0, 0, 0);
    check("rearm_clears_fs", int'(bus.false_start), 0);
    pulse(0, 1, 0, 0);
    expect_ev(2, 9999);
    ticks(9998);
    check("before_timeout_flag", int'(bus.timeout), 0);
    ticks(1);
    check("timeout_flag", int'(bus.timeout), 1);
    check("timeout_reaction_ms", int'(bus.reaction_ms), 9999);
    check("timeout_stim_led", int'(bus.stim_led), 0);
    pulse(1, 0, 0, 0);
    check("rearm_clears_timeout", int'(bus.timeout), 0);

    // Simultaneous delay and response while waiting: false start
    expect_ev(1, 9999);
    pulse(0, 1, 1, 0);
    check("simul_fs_flag", int'(bus.false_start), 1);
    check("simul_fs_stim", int'(bus.stim_led), 0);

    // Response together with a tick at count=50 reports 50
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    ticks(50);
    expect_ev(0, 50);
    pulse(0, 0, 1, 1);
    check("resp_tick_reaction_ms", int'(bus.reaction_ms), 50);

    // Asynchronous reset mid-measurement at count=120
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    ticks(120);
    rst = 1'b0;
    #2;
    check_idle_outputs("async_reset");
    step(2);
    rst = 1'b1;
    step(1);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    check_idle_outputs("post_reset_ignored");
    pulse(1, 0, 0, 0);
    check("post_reset_arm_busy", int'(bus.busy), 1);
    pulse(0, 0, 0, 0);

`ifdef REACTION_TIMER_STATS_EN
    good_trial(200);
    good_trial(300);
    good_trial(100);
    good_trial(400);
    check("stats4_best_ms", int'(bus.best_ms), 100);
    check("stats4_avg_ms", int'(bus.avg_ms), 250);
    good_trial(500);
    check("stats5_best_ms", int'(bus.best_ms), 100);
    check("stats5_avg_ms", int'(bus.avg_ms), 325);
`else
    good_trial(42);
    check("plain_trial_reaction_ms", int'(bus.reaction_ms), 42);
`endif

    step(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Downstream stage of the random-delay generator in the reaction-time tester.
- Arms on the start button and lights the stimulus when the delay pulse arrives.
- Counts milliseconds until the response button pulse, then reports the reaction time.
- Flags false starts and timeouts; feeds the display/BCD stage.

Parameters:
- W, 14, width of the ms counter and result buses (holds 0..9999).
- MAX_MS, 9999, timeout threshold and saturation value in ms.
- TRIALS, 4, depth of the statistics window; must be a power of 2 (used only with STATS_EN).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- tick_1ms  in  1  one-cycle enable every 1 ms; the counter advances only on this.
- start_pulse  in  1  one-cycle debounced start-button pulse; arms or re-arms a trial.
- delay_pulse  in  1  one-cycle pulse from the random-delay stage that marks stimulus onset.
- resp_pulse  in  1  one-cycle debounced response-button pulse.
- stim_led  out  1  high while waiting for the response (state MEASURE).
- reaction_ms  out  W  last measured reaction time in ms.
- result_valid  out  1  one-cycle pulse when reaction_ms is updated by a good trial.
- false_start  out  1  level; response arrived before the stimulus.
- timeout  out  1  level; no response within MAX_MS.
- busy  out  1  high in states WAIT_STIM and MEASURE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, count=0.
  - All outputs 0: reaction_ms=0, stim_led=0, result_valid=0, false_start=0, timeout=0, busy=0.
- FSM states: IDLE, WAIT_STIM, MEASURE, DONE, FAULT.
- IDLE: on start_pulse -> WAIT_STIM; count cleared to 0, false_start and timeout cleared.
- WAIT_STIM:
  - delay_pulse -> MEASURE with count=0; stim_led rises the next cycle.
  - resp_pulse -> FAULT, false_start=1.
  - resp_pulse and delay_pulse in the same cycle: treated as a false start (response wins).
  - start_pulse: stay in WAIT_STIM (re-arm, no flag change).
- MEASURE:
  - On tick_1ms, count increments by 1.
  - resp_pulse -> DONE; reaction_ms <= count (the pre-increment value if tick_1ms is also high); result_valid pulses for 1 cycle, registered in the cycle after resp_pulse is sampled.
  - tick_1ms with count==MAX_MS-1 -> FAULT; timeout=1, reaction_ms <= MAX_MS, no result_valid.
  - start_pulse -> aborts the trial and goes to WAIT_STIM; reaction_ms is unchanged.
- DONE / FAULT:
  - Outputs hold.
  - start_pulse -> WAIT_STIM and clears false_start and timeout.
  - delay_pulse and resp_pulse are ignored.
- delay_pulse is ignored in every state other than WAIT_STIM.
- count never exceeds MAX_MS (saturating); no wrap-around.
- Reset asserted mid-trial: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro: REACTION_TIMER_STATS_EN.
- When defined:
  - Extra outputs best_ms[W-1:0] and avg_ms[W-1:0].
  - Reset values: best_ms=MAX_MS, avg_ms=0.
  - On each result_valid: best_ms = min(best_ms, reaction_ms); the result is pushed into a TRIALS-deep history and avg_ms = sum/TRIALS (right shift by log2(TRIALS)).
  - Empty history slots count as 0.
  - Sum register is W+log2(TRIALS) bits wide.
  - best_ms and avg_ms update 1 cycle after result_valid.
  - False starts and timeouts do not enter the statistics.
- When undefined: these ports and registers do not exist, and the core behaviour is identical.

Test Plan:
- Reset -> start_pulse -> delay_pulse -> 237 ticks -> resp_pulse: stim_led high during measurement, then reaction_ms=237, result_valid high for exactly 1 cycle, false_start=0, timeout=0.
- start_pulse -> resp_pulse before delay_pulse: false_start=1, state FAULT, stim_led never high, reaction_ms unchanged; a later delay_pulse is ignored.
- start_pulse -> delay_pulse -> no response for 9999 ticks: timeout=1, reaction_ms=9999, no result_valid; the next start_pulse clears timeout.
- Simultaneous delay_pulse and resp_pulse in WAIT_STIM: false_start=1. Simultaneous resp_pulse and tick_1ms at count=50: reaction_ms=50.
- rst=0 asserted mid-MEASURE at count=120: all outputs 0 asynchronously, state IDLE; after release, delay_pulse and resp_pulse are ignored until start_pulse.
- With REACTION_TIMER_STATS_EN, trials of 200, 300, 100, 400 ms: best_ms=100, avg_ms=250. A fifth trial of 500 gives avg_ms=325, best_ms=100.
